// File: rtl/envio_resposta_uart_pkg.sv
// Shared codes, default baud divisor and state encodings for the UART response path.
// Latency: none (constants and types only).
// Backpressure: none (constants and types only).
package envio_resposta_uart_pkg;

   // 50 MHz core clock / 9600 baud
   localparam int DEFAULT_CLKS_PER_BIT = 5208;

   // Request codes decoded upstream
   localparam logic [7:0] REQ_CODE_01 = 8'h01;
   localparam logic [7:0] REQ_CODE_02 = 8'h02;
   localparam logic [7:0] REQ_CODE_03 = 8'h03;
   localparam logic [7:0] REQ_CODE_04 = 8'h04;
   localparam logic [7:0] REQ_CODE_05 = 8'h05;
   localparam logic [7:0] REQ_CODE_06 = 8'h06;
   localparam logic [7:0] REQ_CODE_AC = 8'hAC;

   // Response codes produced by the sensor-connection block
   localparam logic [7:0] RESP_CODE_07    = 8'h07;
   localparam logic [7:0] RESP_HUMIDITY   = 8'h08;
   localparam logic [7:0] RESP_TEMP       = 8'h09;
   localparam logic [7:0] RESP_CODE_0A    = 8'h0A;
   localparam logic [7:0] RESP_CODE_0B    = 8'h0B;
   localparam logic [7:0] RESP_CODE_0D    = 8'h0D;
   localparam logic [7:0] RESP_CODE_0E    = 8'h0E;
   localparam logic [7:0] RESP_CODE_1F    = 8'h1F;
   localparam logic [7:0] RESP_ERROR      = 8'h45;
   localparam logic [7:0] RESP_CODE_FF    = 8'hFF;
   localparam logic [7:0] RESP_CODE_AB    = 8'hAB;

   // State encodings
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_STOP  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   // Bit-level serialiser states
   typedef enum logic [2:0] {
      TX_IDLE  = ST_IDLE,
      TX_START = ST_START,
      TX_DATA  = ST_DATA,
      TX_STOP  = ST_STOP
   } tx_state_t;

   // Byte sequencer states: SEQ_SEND spans start/data/stop of both bytes
   typedef enum logic [2:0] {
      SEQ_IDLE = ST_IDLE,
      SEQ_SEND = ST_START,
      SEQ_DONE = ST_DONE
   } seq_state_t;

   // Baud counter width, never below one bit
   function automatic int baud_width(input int clks);
      return (clks > 1) ? $clog2(clks) : 1;
   endfunction

endpackage

// File: rtl/envio_resposta_uart_tx_byte.sv
// Serialises one 8N1 byte (LSB first) with 1 or 2 stop bits; start may chain the next byte.
// Latency: start bit driven the cycle after start; byte_done flags the last stop-bit cycle.
// Backpressure: start is only honoured when idle or on the byte_done cycle; otherwise ignored.
module uart_tx_byte
   import envio_resposta_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int STOP_BITS    = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx,
   output logic       active,
   output logic       byte_done
);

   localparam int                BAUD_W    = baud_width(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

   tx_state_t         state, state_nxt;
   logic [BAUD_W-1:0] baud, baud_nxt;
   logic [2:0]        bit_idx, bit_nxt;
   logic              stop_idx, stop_nxt;
   logic [7:0]        shreg, shreg_nxt;
   logic              tx_nxt;
   logic              bit_end;

   assign bit_end = (baud == BAUD_LAST);
   assign active  = (state != TX_IDLE);

   // State, counters and the registered line driver
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= TX_IDLE;
         baud     <= '0;
         bit_idx  <= '0;
         stop_idx <= 1'b0;
         shreg    <= '0;
         tx       <= 1'b1;
      end else begin
         state    <= state_nxt;
         baud     <= baud_nxt;
         bit_idx  <= bit_nxt;
         stop_idx <= stop_nxt;
         shreg    <= shreg_nxt;
         tx       <= tx_nxt;
      end
   end

   // Next-state: each bit lasts CLKS_PER_BIT cycles; the line value is decided one cycle ahead
   always_comb begin
      state_nxt = state;
      baud_nxt  = baud;
      bit_nxt   = bit_idx;
      stop_nxt  = stop_idx;
      shreg_nxt = shreg;
      tx_nxt    = tx;
      byte_done = 1'b0;
      case (state)
         TX_IDLE: begin
            tx_nxt = 1'b1;
            if (start) begin
               state_nxt = TX_START;
               baud_nxt  = '0;
               shreg_nxt = data;
               tx_nxt    = 1'b0;
            end
         end
         TX_START: begin
            if (bit_end) begin
               state_nxt = TX_DATA;
               baud_nxt  = '0;
               bit_nxt   = 3'd0;
               tx_nxt    = shreg[0];
            end else begin
               baud_nxt = baud + BAUD_W'(1);
            end
         end
         TX_DATA: begin
            if (bit_end) begin
               baud_nxt = '0;
               if (bit_idx == 3'd7) begin
                  state_nxt = TX_STOP;
                  stop_nxt  = 1'b0;
                  tx_nxt    = 1'b1;
               end else begin
                  bit_nxt = bit_idx + 3'd1;
                  tx_nxt  = shreg[bit_idx + 3'd1];
               end
            end else begin
               baud_nxt = baud + BAUD_W'(1);
            end
         end
         TX_STOP: begin
            if (bit_end) begin
               baud_nxt = '0;
               if (stop_idx == STOP_LAST) begin
                  byte_done = 1'b1;
                  // Chaining straight into the next start bit leaves no idle gap
                  if (start) begin
                     state_nxt = TX_START;
                     shreg_nxt = data;
                     tx_nxt    = 1'b0;
                  end else begin
                     state_nxt = TX_IDLE;
                     tx_nxt    = 1'b1;
                  end
               end else begin
                  stop_nxt = stop_idx + 1'b1;
               end
            end else begin
               baud_nxt = baud + BAUD_W'(1);
            end
         end
         default: begin
            state_nxt = TX_IDLE;
            tx_nxt    = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/envio_resposta_uart.sv
// Sends the (command, value) response pair to the host as two back-to-back 8N1 bytes.
// Latency: first start bit one cycle after the request edge; done one cycle after the last stop bit.
// Backpressure: none; a request edge while busy is dropped and flagged in sticky overrun.
module envio_resposta_uart
   import envio_resposta_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int STOP_BITS    = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       dados_prontos,
   input  logic [7:0] response_command,
   input  logic [7:0] response_value,
   output logic       tx,
   output logic       busy,
   output logic       done,
   output logic       overrun
);

   seq_state_t state, state_nxt;
   logic       byte_sel, byte_sel_nxt;
   logic       prev;
   logic       req_edge;
   logic       capture;
   logic [7:0] value_shadow;
   logic       start;
   logic [7:0] byte_data;
   logic       byte_done;
   logic       active;

   assign req_edge = dados_prontos & ~prev;
   assign busy     = (state == SEQ_SEND);
   assign done     = (state == SEQ_DONE);

   // Sequencer state, edge history, value shadow and sticky overrun
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= SEQ_IDLE;
         byte_sel     <= 1'b0;
         prev         <= 1'b0;
         value_shadow <= '0;
         overrun      <= 1'b0;
      end else begin
         state    <= state_nxt;
         byte_sel <= byte_sel_nxt;
         prev     <= dados_prontos;
         if (capture) begin
            value_shadow <= response_value;
         end
         if (req_edge && !capture) begin
            overrun <= 1'b1;
         end
      end
   end

   // Byte sequencing: command goes straight into the serialiser's own shift
   // register on capture, so only the value byte needs a shadow here
   always_comb begin
      state_nxt    = state;
      byte_sel_nxt = byte_sel;
      capture      = 1'b0;
      start        = 1'b0;
      byte_data    = value_shadow;
      case (state)
         SEQ_IDLE: begin
            if (req_edge && !active) begin
               capture      = 1'b1;
               start        = 1'b1;
               byte_data    = response_command;
               byte_sel_nxt = 1'b0;
               state_nxt    = SEQ_SEND;
            end
         end
         SEQ_SEND: begin
            if (byte_done) begin
               if (!byte_sel) begin
                  start        = 1'b1;
                  byte_sel_nxt = 1'b1;
               end else begin
                  state_nxt = SEQ_DONE;
               end
            end
         end
         SEQ_DONE: begin
            state_nxt = SEQ_IDLE;
         end
         default: begin
            state_nxt = SEQ_IDLE;
         end
      endcase
   end

   uart_tx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .STOP_BITS    (STOP_BITS)
   ) u_tx (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .data      (byte_data),
      .tx        (tx),
      .active    (active),
      .byte_done (byte_done)
   );

endmodule

// File: tb/tb_envio_resposta_uart.sv
// Self-checking bench for envio_resposta_uart with a 4-clock bit time.
// Latency: frames checked cycle by cycle against tabulated and modelled bit patterns.
// Backpressure: not applicable; request edges are driven directly.
module tb_envio_resposta_uart;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       dados_prontos = 1'b0;
   logic [7:0] response_command = '0;
   logic [7:0] response_value = '0;
   logic       tx, busy, done, overrun;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0]  cmd;
      logic [7:0]  val;
      logic [0:19] frame;
   } vec_t;

   vec_t vecs[6];

   envio_resposta_uart #(
      .CLKS_PER_BIT (4),
      .STOP_BITS    (1)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .dados_prontos    (dados_prontos),
      .response_command (response_command),
      .response_value   (response_value),
      .tx               (tx),
      .busy             (busy),
      .done             (done),
      .overrun          (overrun)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference: start bit, 8 data bits LSB first, stop bit, for each byte in turn
   function automatic logic [0:19] model_frame(input logic [7:0] c, input logic [7:0] v);
      logic [0:19] f;
      logic [7:0]  b;
      for (int n = 0; n < 2; n++) begin
         b = (n == 0) ? c : v;
         f[n*10] = 1'b0;
         for (int k = 0; k < 8; k++) begin
            f[n*10 + 1 + k] = ((b >> k) & 8'h01) != 8'h00;
         end
         f[n*10 + 9] = 1'b1;
      end
      return f;
   endfunction

   // evt_kind: 0 none, 1 second request edge, 2 input change, 3 drop request low
   task automatic run_frame(input string name, input logic [7:0] cmd, input logic [7:0] val,
                            input logic [0:19] exp, input int evt_j, input int evt_kind,
                            input logic [7:0] cmd2, input logic [7:0] val2, input bit skip_pre);
      int bad = 0;
      if (!skip_pre) begin
         dados_prontos = 1'b0;
         tick();
      end
      response_command = cmd;
      response_value   = val;
      dados_prontos    = 1'b1;
      tick();
      for (int j = 0; j < 80; j++) begin
         if (busy !== 1'b1 || done !== 1'b0) bad++;
         if (j == 0) chk($sformatf("%s start bit on first cycle", name), tx, 0);
         if (j % 4 == 2) chk($sformatf("%s tx bit %0d", name, j / 4), tx, exp[j/4]);
         if (j == evt_j) begin
            case (evt_kind)
               1: begin response_command = cmd2; response_value = val2; dados_prontos = 1'b0; end
               2: begin response_command = cmd2; response_value = val2; end
               3: dados_prontos = 1'b0;
               default: ;
            endcase
         end
         if (evt_kind == 1 && j == evt_j + 1) dados_prontos = 1'b1;
         tick();
      end
      chk($sformatf("%s busy/done during frame (bad cycles)", name), bad, 0);
      chk($sformatf("%s done pulse", name), done, 1);
      chk($sformatf("%s busy after frame", name), busy, 0);
      chk($sformatf("%s tx idle after frame", name), tx, 1);
      tick();
      chk($sformatf("%s done one cycle", name), done, 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      dados_prontos = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();
      chk("overrun cleared by reset", overrun, 0);
   endtask

   initial begin
      int bad;
      logic [7:0] rc, rv;

      vecs[0] = '{8'h09, 8'h1A, 20'b0100100001_0010110001};
      vecs[1] = '{8'h45, 8'h45, 20'b0101000101_0101000101};
      vecs[2] = '{8'hFF, 8'hFF, 20'b0111111111_0111111111};
      vecs[3] = '{8'hAB, 8'hAB, 20'b0110101011_0110101011};
      vecs[4] = '{8'h00, 8'h80, 20'b0000000001_0000000011};
      vecs[5] = '{8'h0D, 8'h19, 20'b0101100001_0100110001};

      // Reset with the request line already high: the first high after reset is an edge
      reset = 1'b1;
      dados_prontos = 1'b1;
      repeat (3) tick();
      chk("reset tx", tx, 1);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset overrun", overrun, 0);
      reset = 1'b0;

      for (int i = 0; i < 6; i++) begin
         run_frame($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].val, vecs[i].frame,
                   -1, 0, 8'h00, 8'h00, i == 0);
      end
      chk("no overrun after table frames", overrun, 0);

      // Level hold: steady high must not retrigger
      bad = 0;
      for (int c = 0; c < 500; c++) begin
         if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
         tick();
      end
      chk("level hold quiet cycles (bad)", bad, 0);

      // Randomised frames against the reference model
      for (int i = 0; i < 12; i++) begin
         rc = 8'($urandom_range(0, 255));
         rv = 8'($urandom_range(0, 255));
         run_frame($sformatf("rand%0d_%02h_%02h", i, rc, rv), rc, rv, model_frame(rc, rv),
                   -1, 0, 8'h00, 8'h00, 1'b0);
      end

      // Overrun: second edge at cycle 30 of a frame
      run_frame("overrun", 8'h09, 8'h1A, model_frame(8'h09, 8'h1A), 28, 1, 8'h08, 8'h37, 1'b0);
      chk("overrun set", overrun, 1);
      bad = 0;
      for (int c = 0; c < 100; c++) begin
         if (tx !== 1'b1 || busy !== 1'b0) bad++;
         tick();
      end
      chk("no frame after dropped request (bad)", bad, 0);
      chk("overrun sticky", overrun, 1);

      // Back-to-back: new edge the cycle after done
      do_reset();
      run_frame("b2b_first", 8'h09, 8'h1A, model_frame(8'h09, 8'h1A), 79, 3, 8'h00, 8'h00, 1'b0);
      run_frame("b2b_second", 8'h0D, 8'h19, model_frame(8'h0D, 8'h19), -1, 0, 8'h00, 8'h00, 1'b1);
      chk("b2b overrun clear", overrun, 0);

      // Inputs change after capture
      run_frame("input_change", 8'h02, 8'h30, model_frame(8'h02, 8'h30), 1, 2, 8'hFF, 8'hFF, 1'b0);

      // Reset mid-frame, then a clean frame
      dados_prontos = 1'b0;
      tick();
      response_command = 8'h11;
      response_value   = 8'h22;
      dados_prontos    = 1'b1;
      tick();
      repeat (44) tick();
      reset = 1'b1;
      tick();
      chk("midreset tx", tx, 1);
      chk("midreset busy", busy, 0);
      chk("midreset done", done, 0);
      reset = 1'b0;
      dados_prontos = 1'b0;
      tick();
      chk("midreset stays idle", busy, 0);
      run_frame("after_reset", 8'h45, 8'h45, model_frame(8'h45, 8'h45), -1, 0, 8'h00, 8'h00, 1'b0);
      chk("after_reset overrun", overrun, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/envio_resposta_uart.md
Name: envio_resposta_uart

Overview:
- Downstream stage of the sensor-connection block.
- Consumes its two-byte response (response command code, response value) when that block raises its data-ready flag.
- Serialises the pair onto the UART TX line toward the host PC: command byte first, value byte second.
- Frame format: 8N1, LSB first.
- Exposes busy, done and overrun status to the top level.

Parameters:
- CLKS_PER_BIT, 5208, clock cycles per UART bit (50 MHz / 9600 baud).
- STOP_BITS, 1, stop bits per byte (1 or 2).

Ports:
- clock  in  1  system clock, 50 MHz; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- dados_prontos  in  1  data-ready level from the sensor-connection block; a rising edge requests a transmission.
- response_command  in  8  response code (e.g. 0x09 temperature, 0x08 humidity, 0x45 error).
- response_value  in  8  measured value or status byte.
- tx  out  1  UART serial line; idle high.
- busy  out  1  high from capture until the last stop bit ends.
- done  out  1  one-cycle pulse after the value byte's final stop bit.
- overrun  out  1  sticky; set when a request edge arrives while busy.

Behaviour:
- Reset values, applied synchronously on reset=1:
  - tx=1, busy=0, done=0, overrun=0.
  - State IDLE; bit counter and baud counter cleared.
  - Edge-detect register cleared, so the first high seen after reset counts as an edge.
  - Reset mid-frame aborts immediately: tx returns to 1 on the next edge, and no partial byte is resumed.
- Trigger:
  - A rising edge of dados_prontos is detected as registered_prev=0 and current=1.
  - A steady high level does not retrigger. The sensor block's continuous mode must pulse dados_prontos low between samples to get one frame per sample.
- Capture (cycle N = edge detected while IDLE):
  - Latch response_command and response_value into shadow registers.
  - Set busy=1.
  - Inputs may change freely after cycle N.
- State machine: IDLE -> START -> DATA -> STOP -> (byte_sel=0 ? START with byte_sel=1 : DONE) -> IDLE.
  - START: tx=0 for CLKS_PER_BIT cycles; starts on cycle N+1.
  - DATA: 8 bits, LSB first; each bit held CLKS_PER_BIT cycles.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - The command byte is sent with byte_sel=0, the value byte with byte_sel=1. There is no idle gap between the two bytes.
  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- Latency:
  - First start bit begins 1 cycle after the edge.
  - Total frame duration is 2*(1+8+STOP_BITS)*CLKS_PER_BIT cycles: 20*CLKS_PER_BIT for STOP_BITS=1.
- Counters:
  - Baud counter width is clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0 on the bit boundary.
  - Bit index is 3 bits, 0..7.
- Simultaneous and boundary events:
  - Edge while busy (including the DONE cycle): request is dropped, overrun<=1, the frame in progress is unaffected.
  - Edge arriving the cycle after DONE (state IDLE): accepted normally.
  - Error responses (0x45/0x45, 0xFF/0xFF, 0xAB/0xAB) are transmitted unchanged. This block does not interpret codes.
- overrun is cleared only by reset.

Decomposition:
- Shared header file (included by this block, the sensor-connection block and the upstream command decoder):
  - Request codes 0x01–0x06, 0xAC.
  - Response codes 0x07, 0x08, 0x09, 0x0A, 0x0B, 0x0D, 0x0E, 0x1F, 0x45, 0xFF, 0xAB.
  - Default CLKS_PER_BIT.
  - State encodings for this FSM (3-bit localparams).
- One natural sub-module: uart_tx_byte.
  - Inputs: clock, reset, start, data[7:0].
  - Outputs: tx, active, byte_done.
  - Parameters: CLKS_PER_BIT, STOP_BITS.
- This block keeps edge detection, capture, byte sequencing, done/busy/overrun, and instantiates uart_tx_byte once.

Test Plan (CLKS_PER_BIT=4, STOP_BITS=1 for simulation):
- Single frame: reset, then dados_prontos 0->1 with command=0x09, value=0x1A.
  - tx samples at bit centres give 0,1,0,0,1,0,0,0,0,1 then 0,0,1,0,1,1,0,0,0,1.
  - busy high for 80 cycles; done pulses at cycle 81 after the edge; overrun=0.
- Level hold: dados_prontos held high 500 cycles after one frame.
  - Exactly one frame is sent; tx stays 1 afterwards.
- Overrun: second edge at cycle 30 of a frame with command=0x08, value=0x37.
  - First frame bytes unchanged; overrun=1 and stays 1; no second frame.
- Back-to-back: second edge (0x0D/0x19) one cycle after the done pulse.
  - Second frame starts its start bit on the next cycle; overrun stays 0.
- Reset mid-frame: reset=1 at cycle 45 of a frame.
  - Next cycle: tx=1, busy=0, done=0; after release, an edge with 0x45/0x45 produces a clean 80-cycle frame.
- Input change after capture: command/value change from 0x02/0x30 to 0xFF/0xFF on cycle N+2.
  - Transmitted bytes are 0x02 then 0x30.
